// File: rtl/bcd_down_timer.sv
// ---------------------------------------------------------------------------
// bcd_down_timer
//
// Multi-digit BCD down-counter for the microwave timer. The count is set by a
// parallel load or by shifting keypad digits in from the right. It then counts
// down one unit per tick while enabled. In mm:ss mode, digit 1 (the seconds
// tens digit) counts modulo 6. A one-cycle done pulse marks the decrement
// that reaches zero.
//
// Ports:
//   clock       in   system clock, rising edge
//   clear       in   synchronous active-high reset (highest priority)
//   loadn       in   active-low parallel load of load_value
//   load_value  in   BCD load value, digit i at [4i+3:4i]
//   key_valid   in   one-cycle strobe: shift key_digit into digit 0
//   key_digit   in   keypad BCD digit
//   enable      in   1 = run, 0 = paused / entry mode
//   tick        in   one-clock count strobe
//   count_out   out  registered BCD count
//   zero        out  combinational: every digit is 0
//   done        out  registered one-cycle pulse when a decrement reaches 0
//   running     out  registered enable & !zero
// ---------------------------------------------------------------------------
module bcd_down_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int MMSS_MODE  = 1
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    loadn,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    key_valid,
    input  logic [3:0]              key_digit,
    input  logic                    enable,
    input  logic                    tick,
    output logic [4*NUM_DIGITS-1:0] count_out,
    output logic                    zero,
    output logic                    done,
    output logic                    running
);

    localparam int W = 4 * NUM_DIGITS;

    // Largest legal value of a digit position.
    function automatic logic [3:0] digit_max(input int idx);
        if (MMSS_MODE != 0 && idx == 1)
            return 4'd5;
        return 4'd9;
    endfunction

    // Clamp a digit to its position's maximum.
    function automatic logic [3:0] sat_digit(input logic [3:0] d, input int idx);
        return (d > digit_max(idx)) ? digit_max(idx) : d;
    endfunction

    logic [W-1:0] count_p0;
    logic         done_p0;
    logic         running_p0;

    logic [W-1:0] load_sat;
    logic [W-1:0] shift_raw;
    logic [W-1:0] shift_next;
    logic [W-1:0] dec_next;
    logic         borrow;
    logic         key_ok;
    logic         dec_ok;

    assign zero   = (count_p0 == '0);
    assign key_ok = key_valid && !enable && (key_digit <= 4'd9);
    assign dec_ok = enable && tick && !zero;

    assign shift_raw = {count_p0[W-5:0], key_digit};

    // Candidate next values for load, key shift and decrement. The borrow
    // ripples from digit 0 upward within the cycle.
    always_comb begin
        load_sat   = '0;
        shift_next = '0;
        dec_next   = '0;
        borrow     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_sat[4*i +: 4]   = sat_digit(load_value[4*i +: 4], i);
            shift_next[4*i +: 4] = sat_digit(shift_raw[4*i +: 4], i);
            if (!borrow) begin
                dec_next[4*i +: 4] = count_p0[4*i +: 4];
            end else if (count_p0[4*i +: 4] == 4'd0) begin
                dec_next[4*i +: 4] = digit_max(i);
            end else begin
                dec_next[4*i +: 4] = count_p0[4*i +: 4] - 4'd1;
                borrow             = 1'b0;
            end
        end
    end

    // Stage p0: count register, done pulse and running flag.
    always_ff @(posedge clock) begin
        if (clear) begin
            count_p0   <= '0;
            done_p0    <= 1'b0;
            running_p0 <= 1'b0;
        end else begin
            running_p0 <= enable && !zero;
            done_p0    <= 1'b0;
            if (!loadn) begin
                count_p0 <= load_sat;
            end else if (key_ok) begin
                count_p0 <= shift_next;
            end else if (dec_ok) begin
                count_p0 <= dec_next;
                done_p0  <= (dec_next == '0);
            end
        end
    end

    assign count_out = count_p0;
    assign done      = done_p0;
    assign running   = running_p0;

endmodule
